// File: rtl/datapath_exec_pkg.sv
// Shared command/opcode definitions for the scheduler-driven X/Y/Z datapath.
// Code values match what the scheduler drives on Tx/Ty/Tz/Tula.
package datapath_exec_pkg;

  localparam int unsigned CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    REG_HOLD   = 4'b0000,
    REG_LOAD   = 4'b0001,
    REG_SHIFTR = 4'b0010,
    REG_SHIFTL = 4'b0011,
    REG_CLEAR  = 4'b0100
  } reg_cmd_e;

  typedef enum logic [CMD_W-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100
  } alu_op_e;

  // One cycle's worth of scheduler commands
  typedef struct packed {
    logic [CMD_W-1:0] tx;
    logic [CMD_W-1:0] ty;
    logic [CMD_W-1:0] tz;
    logic [CMD_W-1:0] tula;
  } exec_cmd_t;

  function automatic logic reg_cmd_legal(input logic [CMD_W-1:0] code);
    return code <= CMD_W'(REG_CLEAR);
  endfunction

  function automatic logic alu_op_legal(input logic [CMD_W-1:0] code);
    return code <= CMD_W'(ALU_XOR);
  endfunction

endpackage

// File: rtl/datapath_exec_reg.sv
// One command-driven datapath register: hold / load / logical shift right / left / clear.
// Undefined command codes hold the register.
module exec_reg
  import datapath_exec_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [CMD_W-1:0] cmd_i,
  input  logic [W-1:0]     load_d_i,
  output logic [W-1:0]     q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      case (reg_cmd_e'(cmd_i))
        REG_LOAD:   q_d = load_d_i;
        REG_SHIFTR: q_d = q_q >> 1;
        REG_SHIFTL: q_d = q_q << 1;
        REG_CLEAR:  q_d = '0;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/datapath_exec.sv
// Executing end of the scheduler interface: X operand, Y accumulator, Z display latch,
// with the ALU, carry/borrow flag and illegal-command flag computed inline.
module datapath_exec
  import datapath_exec_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] Tx,
  input  logic [CMD_W-1:0] Ty,
  input  logic [CMD_W-1:0] Tz,
  input  logic [CMD_W-1:0] Tula,
  input  logic [W-1:0]     data_in,
  output logic [W-1:0]     x_out,
  output logic [W-1:0]     y_out,
  output logic [W-1:0]     z_out,
  output logic             carry,
  output logic             zero,
  output logic             illegal_cmd
);

  exec_cmd_t        cmd_c;
  logic [W:0]       alu_wide_c;
  logic [W-1:0]     alu_result_c;
  logic             alu_carry_c;
  logic             alu_legal_c;
  logic             any_illegal_c;
  logic [CMD_W-1:0] y_cmd_c;
  logic             carry_q;
  logic             carry_d;
  logic             illegal_q;
  logic             illegal_d;
  logic [W-1:0]     x_q;
  logic [W-1:0]     y_q;
  logic [W-1:0]     z_q;

  assign cmd_c = '{tx: Tx, ty: Ty, tz: Tz, tula: Tula};

  // ALU on pre-edge X/Y; bit W carries the add carry or the subtract borrow
  always_comb begin
    alu_wide_c = '0;
    case (alu_op_e'(cmd_c.tula))
      ALU_ADD: alu_wide_c = {1'b0, x_q} + {1'b0, y_q};
      ALU_SUB: alu_wide_c = {1'b0, y_q} - {1'b0, x_q};
      ALU_AND: alu_wide_c = {1'b0, x_q & y_q};
      ALU_OR:  alu_wide_c = {1'b0, x_q | y_q};
      ALU_XOR: alu_wide_c = {1'b0, x_q ^ y_q};
      default: alu_wide_c = '0;
    endcase
  end

  assign alu_result_c = alu_wide_c[W-1:0];
  assign alu_carry_c  = alu_wide_c[W];
  assign alu_legal_c  = alu_op_legal(cmd_c.tula);

  assign any_illegal_c = !reg_cmd_legal(cmd_c.tx) || !reg_cmd_legal(cmd_c.ty) ||
                         !reg_cmd_legal(cmd_c.tz) || !alu_legal_c;

  // A Y load with an undefined opcode degrades to hold
  assign y_cmd_c = (cmd_c.ty == CMD_W'(REG_LOAD) && !alu_legal_c) ? CMD_W'(REG_HOLD) : cmd_c.ty;

  exec_reg #(.W(W)) u_x_reg (
    .clk      (clk),
    .reset    (reset),
    .en_i     (cmd_valid),
    .cmd_i    (cmd_c.tx),
    .load_d_i (data_in),
    .q_o      (x_q)
  );

  exec_reg #(.W(W)) u_y_reg (
    .clk      (clk),
    .reset    (reset),
    .en_i     (cmd_valid),
    .cmd_i    (y_cmd_c),
    .load_d_i (alu_result_c),
    .q_o      (y_q)
  );

  exec_reg #(.W(W)) u_z_reg (
    .clk      (clk),
    .reset    (reset),
    .en_i     (cmd_valid),
    .cmd_i    (cmd_c.tz),
    .load_d_i (y_q),
    .q_o      (z_q)
  );

  always_comb begin
    carry_d   = carry_q;
    illegal_d = 1'b0;
    if (cmd_valid) begin
      illegal_d = any_illegal_c;
      if (cmd_c.ty == CMD_W'(REG_LOAD) && alu_legal_c) carry_d = alu_carry_c;
      else if (cmd_c.ty == CMD_W'(REG_CLEAR))          carry_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign z_out       = z_q;
  assign carry       = carry_q;
  assign zero        = (y_q == '0);
  assign illegal_cmd = illegal_q;

endmodule
